// File: rtl/booth_product_accumulator_if.sv
// Handshake bundle between the Booth multiplier stage, the frame accumulator
// and the result consumer.
interface booth_product_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             start;
  logic [3:0]       len;
  logic [7:0]       product;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             busy;

  modport master (
    output start, len, product, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, overflow, busy
  );

  modport slave (
    input  start, len, product, in_valid, out_ready,
    output in_ready, acc_out, out_valid, overflow, busy
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// Sums a frame of 1..16 signed 8-bit products into a saturating ACC_W-bit
// accumulator and presents the frame sum over a valid/ready handshake.
module booth_product_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  booth_product_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [ACC_W-1:0] acc_r;
  logic [4:0]       count_r;
  logic [4:0]       len_r;
  logic             overflow_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             accept_s;
  logic             last_s;
  logic [ACC_W:0]   sat_result_s;

  // Add at ACC_W+1 bits and clamp; the MSB of the result flags a clamp.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [7:0]       p);
    logic [ACC_W:0] wide;
    logic [ACC_W:0] res;
    wide = {a[ACC_W-1], a} + {{(ACC_W-7){p[7]}}, p};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      if (wide[ACC_W]) begin
        res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      res = {1'b0, wide[ACC_W-1:0]};
    end
    return res;
  endfunction

  // Product acceptance and end-of-frame detection.
  always_comb begin
    accept_s     = 1'b0;
    last_s       = 1'b0;
    sat_result_s = sat_add(acc_r, bus.product);
    if (state_r == ST_ACCUM) begin
      accept_s = bus.in_valid;
      last_s   = bus.in_valid && (count_r == (len_r - 5'd1));
    end else begin
      accept_s = 1'b0;
      last_s   = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ST_ACCUM);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // Frame datapath: results persist after the handshake until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r      <= {ACC_W{1'b0}};
      count_r    <= 5'd0;
      len_r      <= 5'd0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            len_r      <= (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
            acc_r      <= {ACC_W{1'b0}};
            count_r    <= 5'd0;
            overflow_r <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r      <= sat_result_s[ACC_W-1:0];
            overflow_r <= overflow_r | sat_result_s[ACC_W];
            count_r    <= count_r + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.acc_out   = acc_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench: drives identical frames into a 12-bit and an 8-bit
// accumulator and compares both against a saturating integer model.
module tb_booth_product_accumulator;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   m_acc12;
  int   m_acc8;
  int   m_ovf12;
  int   m_ovf8;

  booth_product_accumulator_if #(.ACC_W(12)) if12 ();
  booth_product_accumulator_if #(.ACC_W(8))  if8 ();

  booth_product_accumulator #(.ACC_W(12)) dut12 (.clk(clk), .rst(rst), .bus(if12));
  booth_product_accumulator #(.ACC_W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [3:0] l, input logic [7:0] p,
                       input logic iv, input logic ordy);
    if12.start = st;  if8.start = st;
    if12.len = l;     if8.len = l;
    if12.product = p; if8.product = p;
    if12.in_valid = iv;  if8.in_valid = iv;
    if12.out_ready = ordy; if8.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int s, input int w, inout int ovf);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (s > hi) begin
      ovf = 1;
      return hi;
    end else if (s < lo) begin
      ovf = 1;
      return lo;
    end
    return s;
  endfunction

  task automatic model_clear();
    m_acc12 = 0; m_acc8 = 0; m_ovf12 = 0; m_ovf8 = 0;
  endtask

  task automatic model_add(input int p);
    m_acc12 = sat(m_acc12 + p, 12, m_ovf12);
    m_acc8  = sat(m_acc8 + p, 8, m_ovf8);
  endtask

  // Compares every output of both instances against the model and the given flags.
  task automatic chk_all(input string tag, input int ir, input int ov, input int bz);
    check_eq({tag, " acc12"}, $signed(if12.acc_out), m_acc12);
    check_eq({tag, " acc8"}, $signed(if8.acc_out), m_acc8);
    check_eq({tag, " ovf12"}, if12.overflow, m_ovf12);
    check_eq({tag, " ovf8"}, if8.overflow, m_ovf8);
    check_eq({tag, " in_ready12"}, if12.in_ready, ir);
    check_eq({tag, " in_ready8"}, if8.in_ready, ir);
    check_eq({tag, " out_valid12"}, if12.out_valid, ov);
    check_eq({tag, " out_valid8"}, if8.out_valid, ov);
    check_eq({tag, " busy12"}, if12.busy, bz);
    check_eq({tag, " busy8"}, if8.busy, bz);
  endtask

  task automatic run_frame(input string tag, input int len_f, input int prods[$],
                           input int max_gap, input int bp, input bit noise);
    int n;
    n = (len_f == 0) ? 16 : len_f;
    chk_all({tag, " idle"}, 0, 0, 0);
    // A product offered alongside start must not be taken.
    drive(1'b1, 4'(len_f), 8'h40, 1'b1, 1'b0);
    tick();
    model_clear();
    drive(1'b0, 4'(len_f), 8'h00, 1'b0, 1'b0);
    chk_all({tag, " started"}, 1, 0, 1);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gaps; g++) begin
        drive(noise & $urandom_range(0, 1), 4'($urandom_range(0, 15)), 8'hFF, 1'b0, 1'b0);
        tick();
        chk_all({tag, " gap"}, 1, 0, 1);
      end
      drive(noise & $urandom_range(0, 1), 4'($urandom_range(0, 15)), 8'(prods[i]), 1'b1, 1'b0);
      tick();
      model_add(prods[i]);
      if (i < n - 1) chk_all({tag, " accum"}, 1, 0, 1);
      else           chk_all({tag, " done"}, 0, 1, 1);
    end
    for (int b = 0; b < bp; b++) begin
      drive(noise & $urandom_range(0, 1), 4'd1, 8'h7F, 1'b1, 1'b0);
      tick();
      chk_all({tag, " hold"}, 0, 1, 1);
    end
    drive(noise, 4'd1, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    chk_all({tag, " handshake"}, 0, 0, 0);
    tick();
    chk_all({tag, " back_idle"}, 0, 0, 0);
  endtask

  initial begin
    int q[$];
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    rst = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    #12;
    chk_all("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    q = '{6, -12, 64, -56};
    run_frame("basic", 4, q, 0, 0, 1'b0);
    q = '{10, 20, -5};
    run_frame("gaps", 3, q, 2, 5, 1'b0);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(64);
    run_frame("len16", 0, q, 0, 1, 1'b0);
    q = '{64, 64, -56};
    run_frame("sat_pos", 3, q, 0, 0, 1'b0);
    q = '{-56, -56, -56};
    run_frame("sat_neg", 3, q, 0, 0, 1'b0);
    q = '{-128, 127, -1};
    run_frame("full_range", 3, q, 1, 1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    drive(1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd5, 8'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd5, 8'd3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd5, 8'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk_all("mid_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("post_rst", 0, 0, 0);
    q = '{-7};
    run_frame("after_rst", 1, q, 0, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int lf;
      int n;
      lf = $urandom_range(0, 15);
      n = (lf == 0) ? 16 : lf;
      q.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) q.push_back(int'($urandom_range(0, 255)) - 128);
        else                           q.push_back(int'($urandom_range(0, 120)) - 56);
      end
      run_frame("rand", lf, q, 2, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
